// File: rtl/act_fetch_rsp_pkg.sv
// Shared types and helpers for the activation fetch responder.
package act_fetch_rsp_pkg;

    localparam int ACT_WIDTH_DEF  = 64;
    localparam int ADDR_WIDTH_DEF = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rsp_state_e;

    // Ceiling log2, used to size occupancy counters.
    function automatic int c_log_2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/act_fetch_rsp_fifo.sv
// Response FIFO: DEPTH x WIDTH, head is read combinationally, count exported.
module act_rsp_fifo
    import act_fetch_rsp_pkg::*;
#(
    parameter int WIDTH = ACT_WIDTH_DEF,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en_i,
    input  logic [WIDTH-1:0]          wr_dat_i,
    input  logic                      rd_en_i,
    output logic [WIDTH-1:0]          rd_dat_o,
    output logic [c_log_2(DEPTH):0]   cnt_o
);
    localparam int AW = c_log_2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;

    // Data array carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_dat_i;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en_i) rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_q + CW'(wr_en_i) - CW'(rd_en_i);
        end
    end

    assign rd_dat_o = mem_q[rd_ptr_q];
    assign cnt_o    = cnt_q;

endmodule

// File: rtl/act_fetch_rsp.sv
// Activation fetch responder: turns fetch pulses into GLB reads and returns
// one word per request, buffering read latency and consumer stalls.
//
// state | meaning
// IDLE  | waiting for TOP_Sta
// RUN   | accepting requests, issuing reads under credit control
// DRAIN | all reads issued, waiting for pipe and FIFO to empty
// DONE  | one-cycle completion pulse
module act_fetch_rsp
    import act_fetch_rsp_pkg::*;
#(
    parameter int ACT_WIDTH  = ACT_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int RD_LAT     = 2,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  TOP_Sta,
    input  logic [ADDR_WIDTH-1:0] CFG_BaseAddr,
    input  logic [ADDR_WIDTH-1:0] CFG_NumAct,
    input  logic                  CTRLACT_PlsFetch,
    input  logic                  CTRLACT_Rdy,
    output logic                  CTRLACT_GetAct,
    output logic [ACT_WIDTH-1:0]  CTRLACT_Act,
    output logic                  GLB_ActRdEn,
    output logic [ADDR_WIDTH-1:0] GLB_ActRdAddr,
    input  logic [ACT_WIDTH-1:0]  GLB_ActRdDat,
    output logic                  ACTRSP_Busy,
    output logic                  ACTRSP_Done,
    output logic                  ACTRSP_Err
);
    localparam int CW = c_log_2(DEPTH) + 1;
    localparam int NW = ADDR_WIDTH + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    rsp_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NW-1:0]         remain_q, remain_d;
    logic [NW-1:0]         pend_q, pend_d;
    logic [CW-1:0]         inflight_q, inflight_d;
    logic [RD_LAT-1:0]     pipe_q, pipe_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  get_q, get_d;
    logic [ACT_WIDTH-1:0]  act_q, act_d;
    logic                  err_q, err_d;
    logic                  busy_q, done_q;

    logic                  start, req, req_ok, issue, proto_err;
    logic                  wr, pop_fifo, bypass, fifo_wr, fifo_empty;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [NW-1:0]         cur_rem, cur_pend, pend_avail;
    logic [CW:0]           credit;
    logic [CW-1:0]         fifo_cnt;
    logic [ACT_WIDTH-1:0]  fifo_rdat;

    // Request accounting, credit-gated issue, delivery and next state.
    // An accepted TOP_Sta is treated like a RUN-state request against freshly
    // loaded counters, so its read issues on the very next cycle.
    always_comb begin
        start      = (state_q == ST_IDLE) && TOP_Sta;
        cur_addr   = start ? CFG_BaseAddr : addr_q;
        cur_rem    = start ? (NW'(CFG_NumAct) + NW'(1)) : remain_q;
        cur_pend   = start ? '0 : pend_q;
        req        = start || ((state_q == ST_RUN) && CTRLACT_PlsFetch);
        req_ok     = req && (cur_pend < cur_rem);
        pend_avail = cur_pend + NW'(req_ok);

        wr         = pipe_q[RD_LAT-1];
        fifo_empty = (fifo_cnt == '0);
        pop_fifo   = !fifo_empty && CTRLACT_Rdy;
        bypass     = fifo_empty && wr && CTRLACT_Rdy;
        fifo_wr    = wr && !bypass;

        // A pop this cycle frees its slot for an issue decided this cycle.
        credit = (CW+1)'(inflight_q) + (CW+1)'(fifo_cnt) - (CW+1)'(pop_fifo);
        issue  = (start || (state_q == ST_RUN)) && (pend_avail != '0)
                 && (credit < DEPTH_C);

        pend_d     = pend_avail - NW'(issue);
        remain_d   = cur_rem - NW'(issue);
        addr_d     = issue ? (cur_addr + ADDR_WIDTH'(1)) : cur_addr;
        rd_en_d    = issue;
        rd_addr_d  = issue ? cur_addr : rd_addr_q;
        inflight_d = inflight_q + CW'(issue) - CW'(wr);

        pipe_d    = '0;
        pipe_d[0] = rd_en_q;
        for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];

        get_d = pop_fifo || bypass;
        act_d = act_q;
        if (pop_fifo)    act_d = fifo_rdat;
        else if (bypass) act_d = GLB_ActRdDat;

        proto_err = 1'b0;
        if (req && !req_ok) proto_err = 1'b1;
        if (CTRLACT_PlsFetch && ((state_q == ST_DRAIN) || (state_q == ST_DONE)
            || ((state_q == ST_IDLE) && !TOP_Sta))) proto_err = 1'b1;
        if (TOP_Sta && (state_q != ST_IDLE)) proto_err = 1'b1;
        err_d = start ? 1'b0 : (err_q || proto_err);

        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (remain_d == '0) ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (issue && (remain_d == '0)) state_d = ST_DRAIN;
            // Waiting one extra cycle on get_q places Done two cycles after
            // the last delivered word.
            ST_DRAIN: if ((inflight_q == '0) && fifo_empty && !get_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM, counters, read pipe and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            pend_q     <= '0;
            inflight_q <= '0;
            pipe_q     <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            get_q      <= 1'b0;
            act_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            pend_q     <= pend_d;
            inflight_q <= inflight_d;
            pipe_q     <= pipe_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            get_q      <= get_d;
            act_q      <= act_d;
            err_q      <= err_d;
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_DONE);
        end
    end

    act_rsp_fifo #(
        .WIDTH (ACT_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (fifo_wr),
        .wr_dat_i (GLB_ActRdDat),
        .rd_en_i  (pop_fifo),
        .rd_dat_o (fifo_rdat),
        .cnt_o    (fifo_cnt)
    );

    assign CTRLACT_GetAct = get_q;
    assign CTRLACT_Act    = act_q;
    assign GLB_ActRdEn    = rd_en_q;
    assign GLB_ActRdAddr  = rd_addr_q;
    assign ACTRSP_Busy    = busy_q;
    assign ACTRSP_Done    = done_q;
    assign ACTRSP_Err     = err_q;

endmodule

// File: tb/tb_act_fetch_rsp.sv
// Scoreboard bench for act_fetch_rsp: expected addresses/words are queued at
// stimulus time, a negedge monitor pops and compares on RdEn and GetAct.
module tb_act_fetch_rsp;
    localparam int ACT_W  = 64;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              TOP_Sta = 1'b0;
    logic [ADDR_W-1:0] CFG_BaseAddr = '0;
    logic [ADDR_W-1:0] CFG_NumAct = '0;
    logic              CTRLACT_PlsFetch = 1'b0;
    logic              CTRLACT_Rdy = 1'b1;
    logic              CTRLACT_GetAct;
    logic [ACT_W-1:0]  CTRLACT_Act;
    logic              GLB_ActRdEn;
    logic [ADDR_W-1:0] GLB_ActRdAddr;
    logic [ACT_W-1:0]  GLB_ActRdDat;
    logic              ACTRSP_Busy, ACTRSP_Done, ACTRSP_Err;

    always #5 clk = ~clk;

    act_fetch_rsp #(.ACT_WIDTH(ACT_W), .ADDR_WIDTH(ADDR_W), .RD_LAT(2), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .TOP_Sta(TOP_Sta),
        .CFG_BaseAddr(CFG_BaseAddr), .CFG_NumAct(CFG_NumAct),
        .CTRLACT_PlsFetch(CTRLACT_PlsFetch), .CTRLACT_Rdy(CTRLACT_Rdy),
        .CTRLACT_GetAct(CTRLACT_GetAct), .CTRLACT_Act(CTRLACT_Act),
        .GLB_ActRdEn(GLB_ActRdEn), .GLB_ActRdAddr(GLB_ActRdAddr),
        .GLB_ActRdDat(GLB_ActRdDat), .ACTRSP_Busy(ACTRSP_Busy),
        .ACTRSP_Done(ACTRSP_Done), .ACTRSP_Err(ACTRSP_Err)
    );

    function automatic logic [63:0] mem_word(input logic [11:0] a);
        return {a ^ 12'h5A5, 20'hC0FFE, a, 20'h12345};
    endfunction

    // GLB model with a two-cycle read latency; junk when no read was issued.
    logic [63:0] sram_p1, sram_p2;
    always @(posedge clk) begin
        sram_p1 <= GLB_ActRdEn ? mem_word(GLB_ActRdAddr) : 64'hDEAD_BEEF_DEAD_BEEF;
        sram_p2 <= sram_p1;
    end
    assign GLB_ActRdDat = sram_p2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0, n_fail = 0;
    int get_cnt = 0, rd_cnt = 0, first_get_cyc = 0, last_get_cyc = 0, t0 = 0;
    logic [63:0] exp_dat_q[$];
    logic [11:0] exp_addr_q[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: compares every read address and delivered word in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (GLB_ActRdEn) begin
                rd_cnt++;
                if (exp_addr_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_rden: got addr 0x%0h, expected no read", GLB_ActRdAddr);
                end else chk("rd_addr", GLB_ActRdAddr, exp_addr_q.pop_front());
            end
            if (CTRLACT_GetAct) begin
                if (get_cnt == 0) first_get_cyc = cyc;
                get_cnt++;
                last_get_cyc = cyc;
                if (exp_dat_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_getact: got 0x%0h, expected no word", CTRLACT_Act);
                end else chk("act_data", CTRLACT_Act, exp_dat_q.pop_front());
            end
            if (ACTRSP_Done) chk("done_gap", 64'(cyc - last_get_cyc), 64'd2);
        end
    end

    task automatic push_exp(input logic [11:0] a);
        exp_addr_q.push_back(a);
        exp_dat_q.push_back(mem_word(a));
    endtask

    // Called at a negedge; returns at the next negedge with strobes cleared.
    task automatic start_run(input logic [11:0] base, input logic [11:0] num, input logic fetch);
        get_cnt = 0; rd_cnt = 0;
        TOP_Sta = 1'b1; CFG_BaseAddr = base; CFG_NumAct = num; CTRLACT_PlsFetch = fetch;
        t0 = cyc;
        @(negedge clk);
        TOP_Sta = 1'b0; CTRLACT_PlsFetch = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!ACTRSP_Done && n < budget) begin @(negedge clk); n++; end
        if (!ACTRSP_Done) begin
            n_tests++; n_fail++;
            $display("FAIL %s_done_timeout: got no Done within %0d cycles, expected Done", name, budget);
        end else begin
            @(negedge clk);
            chk({name, "_busy_after_done"}, ACTRSP_Busy, 64'd0);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_getact"}, CTRLACT_GetAct, 64'd0);
        chk({name, "_act"},    CTRLACT_Act, 64'd0);
        chk({name, "_rden"},   GLB_ActRdEn, 64'd0);
        chk({name, "_rdaddr"}, GLB_ActRdAddr, 64'd0);
        chk({name, "_busy"},   ACTRSP_Busy, 64'd0);
        chk({name, "_done"},   ACTRSP_Done, 64'd0);
        chk({name, "_err"},    ACTRSP_Err, 64'd0);
    endtask

    task automatic basic_run(input string tag);
        logic [11:0] addrs [4];
        int fetches, n;
        addrs = '{12'h010, 12'h011, 12'h012, 12'h013};
        foreach (addrs[i]) push_exp(addrs[i]);
        chk({tag, "_busy_before"}, ACTRSP_Busy, 64'd0);
        start_run(12'h010, 12'd3, 1'b0);
        chk({tag, "_busy_rise"}, ACTRSP_Busy, 64'd1);
        fetches = 0; n = 0;
        while (fetches < 3 && n < 100) begin
            if (CTRLACT_GetAct) begin CTRLACT_PlsFetch = 1'b1; fetches++; end
            else CTRLACT_PlsFetch = 1'b0;
            @(negedge clk); n++;
        end
        CTRLACT_PlsFetch = 1'b0;
        chk({tag, "_fetches_sent"}, 64'(fetches), 64'd3);
        wait_done(tag, 50);
        chk({tag, "_get_cnt"}, 64'(get_cnt), 64'd4);
        chk({tag, "_rd_cnt"},  64'(rd_cnt), 64'd4);
        chk({tag, "_err"},     ACTRSP_Err, 64'd0);
        chk({tag, "_leftover"}, 64'(exp_dat_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        logic [11:0] wrap_addrs [4];
        wrap_addrs = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};

        // Reset state
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Basic run
        basic_run("basic");

        // Back-to-back: PlsFetch for 8 cycles starting with TOP_Sta
        for (int i = 0; i < 8; i++) push_exp(12'h100 + 12'(i));
        start_run(12'h100, 12'd7, 1'b1);
        CTRLACT_PlsFetch = 1'b1;
        repeat (7) @(negedge clk);
        CTRLACT_PlsFetch = 1'b0;
        wait_done("b2b", 50);
        chk("b2b_get_cnt", 64'(get_cnt), 64'd8);
        chk("b2b_first_latency", 64'(first_get_cyc - t0), 64'd4);
        chk("b2b_span", 64'(last_get_cyc - first_get_cyc), 64'd7);
        chk("b2b_err", ACTRSP_Err, 64'd0);

        // Stall: 8 requests with Rdy low for 20 cycles
        CTRLACT_Rdy = 1'b0;
        for (int i = 0; i < 8; i++) push_exp(12'h200 + 12'(i));
        start_run(12'h200, 12'd7, 1'b1);
        CTRLACT_PlsFetch = 1'b1;
        repeat (7) @(negedge clk);
        CTRLACT_PlsFetch = 1'b0;
        repeat (12) @(negedge clk);
        chk("stall_rd_cnt", 64'(rd_cnt), 64'd4);
        chk("stall_get_cnt", 64'(get_cnt), 64'd0);
        CTRLACT_Rdy = 1'b1;
        @(negedge clk);
        chk("stall_resume_rden", GLB_ActRdEn, 64'd1);
        chk("stall_first_get", CTRLACT_GetAct, 64'd1);
        wait_done("stall", 100);
        chk("stall_total_get", 64'(get_cnt), 64'd8);
        chk("stall_total_rd", 64'(rd_cnt), 64'd8);
        chk("stall_err", ACTRSP_Err, 64'd0);

        // Wrap and overrun: 5 requests for a 4-word run
        foreach (wrap_addrs[i]) push_exp(wrap_addrs[i]);
        start_run(12'hFFE, 12'd3, 1'b1);
        CTRLACT_PlsFetch = 1'b1;
        repeat (4) @(negedge clk);
        CTRLACT_PlsFetch = 1'b0;
        chk("overrun_err", ACTRSP_Err, 64'd1);
        wait_done("wrap", 50);
        chk("wrap_get_cnt", 64'(get_cnt), 64'd4);
        chk("wrap_err_sticky", ACTRSP_Err, 64'd1);

        // TOP_Sta during RUN is ignored and flags Err
        push_exp(12'h300);
        push_exp(12'h301);
        start_run(12'h300, 12'd1, 1'b0);
        chk("start_clears_err", ACTRSP_Err, 64'd0);
        TOP_Sta = 1'b1; CFG_BaseAddr = 12'h777; CTRLACT_PlsFetch = 1'b1;
        @(negedge clk);
        TOP_Sta = 1'b0; CTRLACT_PlsFetch = 1'b0;
        chk("sta_in_run_err", ACTRSP_Err, 64'd1);
        wait_done("sta_in_run", 50);
        chk("sta_in_run_get_cnt", 64'(get_cnt), 64'd2);
        chk("sta_in_run_err_sticky", ACTRSP_Err, 64'd1);

        // Reset mid-run with two reads in flight
        for (int i = 0; i < 8; i++) push_exp(12'h400 + 12'(i));
        start_run(12'h400, 12'd7, 1'b1);
        CTRLACT_PlsFetch = 1'b1;
        @(negedge clk);
        CTRLACT_PlsFetch = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("midrun_reset");
        exp_dat_q.delete();
        exp_addr_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        basic_run("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
